// File: rtl/imem_load_ctrl_if.sv
// Bus bundle for the instruction-memory loader: byte load stream, memory
// write port, fetch/read address path and load status.
interface imem_load_ctrl_if;
  logic        start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] fetch_addr;
  logic [31:0] mem_raddr;
  logic        cpu_stall;
  logic        load_done;
  logic        load_err;
  logic [31:0] word_count;

  modport slave (
    input  start, ld_valid, ld_data, ld_last, fetch_addr,
    output ld_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
           cpu_stall, load_done, load_err, word_count
  );

  modport master (
    output start, ld_valid, ld_data, ld_last, fetch_addr,
    input  ld_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
           cpu_stall, load_done, load_err, word_count
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction memory load sequencer: stalls the CPU, packs a byte stream into
// big-endian 32-bit words written from address 0, then hands reads to fetch.
module imem_load_ctrl #(
  parameter int MEM_BYTES = 256
) (
  input  logic           clk,
  input  logic           rst,
  imem_load_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_t;

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  state_t      r_state;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_acc;
  logic [31:0] r_next_addr;
  logic        r_mem_we;
  logic [31:0] r_mem_waddr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_word_count;
  logic        r_load_err;

  logic        w_accept;
  logic        w_complete;
  logic        w_in_range;
  logic [4:0]  w_shift;
  logic [31:0] w_word;

  assign w_accept   = bus.ld_valid && (r_state == LOAD);
  assign w_complete = w_accept && ((r_byte_idx == 2'd3) || bus.ld_last);
  assign w_in_range = (r_next_addr <= LAST_ADDR);

  // Byte index 0 lands in the top byte: shift = 8*(3-idx) = {~idx, 3'b000}.
  assign w_shift = {~r_byte_idx, 3'b000};
  assign w_word  = r_acc | ({24'd0, bus.ld_data} << w_shift);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_byte_idx   <= 2'd0;
      r_acc        <= 32'd0;
      r_next_addr  <= 32'd0;
      r_mem_we     <= 1'b0;
      r_mem_waddr  <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_word_count <= 32'd0;
      r_load_err   <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        IDLE, RUN: begin
          if (bus.start) begin
            r_state      <= LOAD;
            r_byte_idx   <= 2'd0;
            r_acc        <= 32'd0;
            r_next_addr  <= 32'd0;
            r_word_count <= 32'd0;
            r_load_err   <= 1'b0;
          end
        end
        LOAD: begin
          if (w_accept) begin
            if (w_complete) begin
              r_byte_idx <= 2'd0;
              r_acc      <= 32'd0;
              // Past the end: keep swallowing bytes until ld_last, flag it.
              if (w_in_range) begin
                r_mem_we     <= 1'b1;
                r_mem_waddr  <= r_next_addr;
                r_mem_wdata  <= w_word;
                r_word_count <= r_word_count + 32'd1;
                r_next_addr  <= r_next_addr + 32'd4;
              end else begin
                r_load_err <= 1'b1;
              end
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_acc      <= w_word;
            end
            if (bus.ld_last) r_state <= DRAIN;
          end
        end
        DRAIN:   r_state <= RUN;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ld_ready   = (r_state == LOAD);
  assign bus.cpu_stall  = (r_state != RUN);
  assign bus.load_done  = (r_state == RUN);
  assign bus.mem_raddr  = (r_state == RUN) ? bus.fetch_addr : 32'd0;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_waddr  = r_mem_waddr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.word_count = r_word_count;
  assign bus.load_err   = r_load_err;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized bench for imem_load_ctrl: byte streams with random gaps are
// checked against a list-of-words model of the expected memory writes.
module tb_imem_load_ctrl;
  localparam int MB = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_load_ctrl_if bus();

  imem_load_ctrl #(.MEM_BYTES(MB)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t         obs_q[$];
  wr_t         exp_q[$];
  logic [7:0]  bq[$];
  logic [31:0] exp_wc;
  logic        exp_err;
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(negedge clk)
    if (bus.mem_we === 1'b1) obs_q.push_back(wr_t'({bus.mem_waddr, bus.mem_wdata}));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory image the load should produce: 4-byte groups, big-endian,
  // zero-padded tail, at 0,4,8,... and dropped once past the memory.
  function automatic void build_expect();
    int n  = bq.size();
    int nw = (n + 3) / 4;
    logic [31:0] d;
    exp_q.delete();
    exp_wc  = 32'd0;
    exp_err = 1'b0;
    for (int w = 0; w < nw; w++) begin
      d = 32'd0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) d[31 - 8 * k -: 8] = bq[4 * w + k];
      if (4 * w + 4 <= MB) begin
        exp_q.push_back(wr_t'({32'(4 * w), d}));
        exp_wc = exp_wc + 32'd1;
      end else begin
        exp_err = 1'b1;
      end
    end
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_stall"}, 32'(bus.cpu_stall), 32'd1);
    chk({tag, "_ready"}, 32'(bus.ld_ready), 32'd0);
    chk({tag, "_we"},    32'(bus.mem_we), 32'd0);
    chk({tag, "_waddr"}, bus.mem_waddr, 32'd0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_wc"},    bus.word_count, 32'd0);
    chk({tag, "_err"},   32'(bus.load_err), 32'd0);
    chk({tag, "_done"},  32'(bus.load_done), 32'd0);
    chk({tag, "_raddr"}, bus.mem_raddr, 32'd0);
  endtask

  task automatic idle_gap(input int n, input bit poke_start);
    repeat (n) begin
      bus.ld_valid = 1'b0;
      bus.ld_data  = 8'($urandom);
      bus.ld_last  = 1'($urandom);
      bus.start    = poke_start;
      tick();
    end
    bus.start   = 1'b0;
    bus.ld_last = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    bit done  = 1'b0;
    int guard = 0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    bus.ld_last  = last;
    while (!done && guard < 20) begin
      done = bus.ld_ready;
      tick();
      guard++;
    end
    if (!done) chk("byte_timeout", 32'd0, 32'd1);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  // gap < 0 alternates valid/idle cycles; otherwise random gaps up to gap.
  task automatic run_load(input int gap, input bit poke);
    int nc;
    obs_q.delete();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ld_stall", 32'(bus.cpu_stall), 32'd1);
    chk("ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("ld_wc",    bus.word_count, 32'd0);
    chk("ld_err",   32'(bus.load_err), 32'd0);
    chk("ld_done",  32'(bus.load_done), 32'd0);
    chk("ld_raddr", bus.mem_raddr, 32'd0);
    for (int i = 0; i < bq.size(); i++) begin
      idle_gap((gap < 0) ? (i % 2) : int'($urandom_range(0, gap)), poke);
      send_byte(bq[i], i == bq.size() - 1);
    end
    chk("drain_stall", 32'(bus.cpu_stall), 32'd1);
    chk("drain_ready", 32'(bus.ld_ready), 32'd0);
    chk("drain_done",  32'(bus.load_done), 32'd0);
    tick();
    bus.fetch_addr = $urandom;
    #1;
    chk("run_done",  32'(bus.load_done), 32'd1);
    chk("run_stall", 32'(bus.cpu_stall), 32'd0);
    chk("run_raddr", bus.mem_raddr, bus.fetch_addr);
    build_expect();
    chk("run_wc",  bus.word_count, exp_wc);
    chk("run_err", 32'(bus.load_err), 32'(exp_err));
    chk("wr_count", 32'(obs_q.size()), 32'(exp_q.size()));
    nc = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nc; i++) begin
      chk("wr_addr", obs_q[i].addr, exp_q[i].addr);
      chk("wr_data", obs_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.start      = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = 8'd0;
    bus.ld_last    = 1'b0;
    bus.fetch_addr = 32'h0000_0040;
    rst            = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_idle("rst");

    // Bytes offered in IDLE must not be taken.
    obs_q.delete();
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h5A;
    bus.ld_last  = 1'b1;
    tick();
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    chk_idle("idle");
    chk("idle_nowr", 32'(obs_q.size()), 32'd0);

    bq = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(0, 1'b0);
    bq = '{8'h8C, 8'h01, 8'h00, 8'h04};
    run_load(-1, 1'b0);
    bq = '{8'hAA, 8'hBB};
    run_load(2, 1'b1);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
           8'h99, 8'hAA, 8'hBB, 8'hCC};
    run_load(1, 1'b1);

    bus.fetch_addr = 32'd4;
    #1;
    chk("fetch4", bus.mem_raddr, 32'd4);
    bq = '{8'hDE, 8'hAD, 8'hBE};
    run_load(0, 1'b1);

    // Reset two bytes into a word.
    obs_q.delete();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    do_reset();
    tick();
    chk_idle("rst2");
    chk("rst2_nowr", 32'(obs_q.size()), 32'd0);

    // Reset on the very edge that would complete the word.
    obs_q.delete();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h04;
    rst          = 1'b1;
    tick();
    bus.ld_valid = 1'b0;
    rst          = 1'b0;
    tick();
    tick();
    chk_idle("rst3");
    chk("rst3_nowr", 32'(obs_q.size()), 32'd0);

    bq = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    run_load(1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      int n = $urandom_range(1, 14);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        do_reset();
        chk_idle("rrst");
      end
      run_load($urandom_range(0, 2), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
